// File: rtl/demod_pkg.sv
// rtl/demod_pkg.sv - shared widths, references, FSM states and reference lookup for the segment scheduler
package demod_pkg;

  localparam int DW = 32;
  localparam logic [DW-1:0] REF_POS = 32'h0001_0000;
  localparam logic [DW-1:0] REF_NEG = 32'hFFFF_0000;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  // Even segments use +1.0 as ref and -1.0 as ref_m; odd segments are swapped.
  function automatic logic [DW-1:0] ref_for(input logic [3:0] k, input logic m);
    return (k[0] ^ m) ? REF_NEG : REF_POS;
  endfunction

endpackage

// File: rtl/demod_decision_slice.sv
// rtl/demod_decision_slice.sv - shared 2-stage nearest-reference decision for one sample per clock
module demod_decision_slice
  import demod_pkg::*;
#(
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_x,
  input  logic [IW-1:0] in_idx,
  input  logic          in_v,
  output logic [IW-1:0] out_idx,
  output logic          out_choice,
  output logic [DW-1:0] out_value,
  output logic          out_v
);

  logic [DW-1:0] ref_k;
  logic [DW-1:0] ref_m;
  logic [DW:0]   x_ext;
  logic [DW:0]   diff0;
  logic [DW:0]   diff1;
  logic [DW:0]   d0;
  logic [DW:0]   d1;

  logic [DW:0]   s1_d0;
  logic [DW:0]   s1_d1;
  logic [IW-1:0] s1_idx;
  logic          s1_v;

  // One extra bit keeps x - ref exact even at the full-scale extremes.
  always_comb begin
    ref_k = ref_for(4'(in_idx), 1'b0);
    ref_m = ref_for(4'(in_idx), 1'b1);
    x_ext = {in_x[DW-1], in_x};
    diff0 = x_ext - {ref_k[DW-1], ref_k};
    diff1 = x_ext - {ref_m[DW-1], ref_m};
    d0    = diff0[DW] ? -diff0 : diff0;
    d1    = diff1[DW] ? -diff1 : diff1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_d0  <= '0;
      s1_d1  <= '0;
      s1_idx <= '0;
      s1_v   <= 1'b0;
    end else begin
      s1_d0  <= d0;
      s1_d1  <= d1;
      s1_idx <= in_idx;
      s1_v   <= in_v;
    end
  end

  // Ties keep ref_k.
  assign out_choice = (s1_d1 < s1_d0);
  assign out_value  = ref_for(4'(s1_idx), out_choice);
  assign out_idx    = s1_idx;
  assign out_v      = s1_v;

endmodule

// File: rtl/demod_segment_scheduler.sv
// rtl/demod_segment_scheduler.sv - sequences a NUM_SEG-sample frame through one shared decision slice
module demod_segment_scheduler
  import demod_pkg::*;
#(
  parameter int NUM_SEG = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_sample,
  output logic                  in_ready,
  output logic [NUM_SEG*DW-1:0] seg_out,
  output logic [NUM_SEG-1:0]    seg_bits,
  output logic                  valid,
  output logic                  busy
);

  localparam int IW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] idx;
  logic          accept;
  logic          last;

  logic [IW-1:0] sl_idx;
  logic          sl_choice;
  logic [DW-1:0] sl_value;
  logic          sl_v;

  assign accept   = (state == LOAD) && in_valid;
  assign last     = (idx == IW'(NUM_SEG - 1));
  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign valid    = (state == DONE);

  demod_decision_slice #(
    .IW(IW)
  ) u_slice (
    .clk       (clk),
    .reset     (reset),
    .in_x      (in_sample),
    .in_idx    (idx),
    .in_v      (accept),
    .out_idx   (sl_idx),
    .out_choice(sl_choice),
    .out_value (sl_value),
    .out_v     (sl_v)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (accept && last) next_state = DRAIN;
      DRAIN:   if (!sl_v) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      seg_out  <= '0;
      seg_bits <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        idx      <= '0;
        seg_bits <= '0;
      end else if (accept && !last) begin
        idx <= idx + IW'(1);
      end
      // Lane writes only ever land outside IDLE, so they never race the clear above.
      if (sl_v) begin
        for (int k = 0; k < NUM_SEG; k++) begin
          if (sl_idx == IW'(k)) begin
            seg_out[k*DW +: DW] <= sl_value;
            seg_bits[k]         <= sl_choice;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demod_segment_scheduler.sv
// tb/tb_demod_segment_scheduler.sv - self-checking bench for demod_segment_scheduler
module tb_demod_segment_scheduler;

  localparam int NS = 10;
  localparam int W  = NS * 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [31:0]   in_sample;
  logic          in_ready;
  logic [W-1:0]  seg_out;
  logic [NS-1:0] seg_bits;
  logic          valid;
  logic          busy;

  demod_segment_scheduler #(.NUM_SEG(NS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_sample(in_sample),
    .in_ready (in_ready),
    .seg_out  (seg_out),
    .seg_bits (seg_bits),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   even_x;
    logic [31:0]   odd_x;
    logic [NS-1:0] exp_bits;
    logic [31:0]   exp_even;
    logic [31:0]   exp_odd;
  } vec_t;

  vec_t          vecs [4];
  logic [31:0]   samp [NS];
  int            n_checks = 0;
  int            n_pass = 0;
  int            c, first_valid, valid_cnt, busy_cnt, busy_first, busy_last, ready_bad;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    if (valid) begin
      if (first_valid < 0) first_valid = c;
      valid_cnt++;
    end
    if (busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = c;
      busy_last = c;
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic clear_obs();
    c = 0; first_valid = -1; valid_cnt = 0; busy_cnt = 0;
    busy_first = -1; busy_last = -1; ready_bad = 0;
  endtask

  // Start at cycle 0, then one accept per cycle except for an optional stall window.
  task automatic run_frame(input int stall_at, input int stall_len, input bit poke);
    int k;
    int stalled;
    k = 0;
    stalled = 0;
    clear_obs();
    start = 1'b1;
    step();
    start = 1'b0;
    while (k < NS) begin
      if (k == stall_at && stalled < stall_len) begin
        in_valid = 1'b0;
        start = poke && (stalled == 1);
        stalled++;
      end else begin
        in_valid = 1'b1;
        in_sample = samp[k];
        start = 1'b0;
        if (in_ready !== 1'b1) ready_bad++;
        k++;
      end
      step();
    end
    in_valid = 1'b0;
    start = 1'b0;
    repeat (6) step();
  endtask

  // Nearest of +1.0 / -1.0 by plain integer distance; ties keep the segment's own ref.
  task automatic model(output logic [NS-1:0] bits, output logic [W-1:0] outv);
    longint x, r, m, d0, d1;
    logic [63:0] v;
    for (int k = 0; k < NS; k++) begin
      x = longint'($signed(samp[k]));
      r = (k % 2 == 0) ? 65536 : -65536;
      m = -r;
      d0 = (x > r) ? x - r : r - x;
      d1 = (x > m) ? x - m : m - x;
      bits[k] = (d1 < d0);
      v = bits[k] ? m : r;
      outv[k*32 +: 32] = v[31:0];
    end
  endtask

  task automatic check_frame(input string name, input int exp_valid,
                             input logic [NS-1:0] eb, input logic [W-1:0] eo);
    check({name, ".valid_cycle"}, W'(first_valid), W'(exp_valid));
    check({name, ".valid_count"}, W'(valid_cnt), W'(1));
    check({name, ".busy_first"}, W'(busy_first), W'(1));
    check({name, ".busy_last"}, W'(busy_last), W'(exp_valid));
    check({name, ".ready_drops"}, W'(ready_bad), W'(0));
    check({name, ".seg_bits"}, W'(seg_bits), W'(eb));
    check({name, ".seg_out"}, seg_out, eo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [NS-1:0] eb;
    logic [W-1:0]  eo;
    int            sa, sl;

    vecs[0] = '{32'h0000_8000, 32'h0000_8000, 10'b10_1010_1010, 32'h0001_0000, 32'h0001_0000};
    vecs[1] = '{32'hFFFF_0000, 32'h0001_0000, 10'b11_1111_1111, 32'hFFFF_0000, 32'h0001_0000};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 10'b00_0000_0000, 32'h0001_0000, 32'hFFFF_0000};
    vecs[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 10'b11_1111_1111, 32'hFFFF_0000, 32'h0001_0000};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_sample = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset.seg_out", seg_out, '0);
    check("reset.seg_bits", W'(seg_bits), '0);
    check("reset.flags", W'({valid, busy, in_ready}), '0);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NS; k++) samp[k] = (k % 2 == 0) ? vecs[i].even_x : vecs[i].odd_x;
      for (int k = 0; k < NS; k++) eo[k*32 +: 32] = (k % 2 == 0) ? vecs[i].exp_even : vecs[i].exp_odd;
      run_frame(-1, 0, 1'b0);
      check_frame($sformatf("vec%0d", i), 13, vecs[i].exp_bits, eo);
    end

    // Stall five cycles after the 4th accept and pulse start mid-stall.
    for (int k = 0; k < NS; k++) samp[k] = (k < 5) ? 32'h0000_8000 : 32'hFFFF_8000;
    model(eb, eo);
    run_frame(4, 5, 1'b1);
    check_frame("stall", 18, eb, eo);
    check("stall.idle_after", W'({valid, busy, in_ready}), '0);

    // Reset one cycle after the 6th accept.
    for (int k = 0; k < NS; k++) samp[k] = 32'h0000_8000;
    clear_obs();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_sample = samp[k];
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset.seg_out", seg_out, '0);
    check("midreset.seg_bits", W'(seg_bits), '0);
    check("midreset.flags", W'({valid, busy, in_ready}), '0);
    clear_obs();
    repeat (6) step();
    check("midreset.no_valid", W'(valid_cnt), '0);
    check("midreset.seg_out_quiet", seg_out, '0);
    for (int k = 0; k < NS; k++) samp[k] = (k % 2 == 0) ? 32'hFFFF_0000 : 32'h0001_0000;
    model(eb, eo);
    run_frame(-1, 0, 1'b0);
    check_frame("after_reset", 13, eb, eo);

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < NS; k++) begin
        case ($urandom_range(0, 2))
          0: samp[k] = $urandom;
          1: samp[k] = 32'($signed($urandom_range(0, 262144)) - 131072);
          default: samp[k] = ($urandom_range(0, 1) != 0) ? 32'h0001_0000 : 32'h0000_0000;
        endcase
      end
      sa = $urandom_range(0, NS - 1);
      sl = $urandom_range(0, 3);
      model(eb, eo);
      run_frame(sa, sl, ($urandom_range(0, 1) != 0));
      check_frame($sformatf("rand%0d", f), 13 + sl, eb, eo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
